upcounter_ctrl: RTL and testbench
=================================

Name: upcounter_ctrl

Overview:
Sequencing controller for a synchronous WIDTH-bit up-counter. It latches a terminal limit, runs the counter at a prescaled tick rate and supports one-shot or periodic operation, pause and abort. It reports busy, a one-cycle done pulse and a completed-period tally. It sits between control logic and the counter datapath, so the raw counter is never driven directly by software or an FSM.

Parameters:
WIDTH, 4, counter and limit width in bits
PRESCALE, 1, clocks per counter tick (>=1)
PW, 8, width of completed-period tally

Ports:
clock  in  1  single clock, rising-edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin a run (honoured only in IDLE)
pause  in  1  level; freezes counter and prescaler while high
abort  in  1  terminate run immediately
periodic  in  1  sampled with start: 1 = auto-reload, 0 = one-shot
limit  in  WIDTH  terminal count, sampled with start
count  out  WIDTH  current counter value
busy  out  1  high in RUN or HOLD
done  out  1  one-clock pulse per completed period
periods  out  PW  completed periods since last start, wraps mod 2^PW

Behaviour:
- Reset (async, active-high): state=IDLE, count=0, prescaler=0, busy=0, done=0, periods=0, limit_q=0, periodic_q=0.
- States: IDLE, RUN, HOLD. Registered outputs only. busy = (state != IDLE).
- Priority at every edge: abort > pause > start > tick.
- IDLE:
  - start=1, abort=0: latch limit->limit_q and periodic->periodic_q; count<=0; prescaler<=0; periods<=0; go to RUN.
  - Otherwise hold. count keeps its last value; after a one-shot it stays at limit_q.
- tick: asserted when state=RUN, pause=0 and prescaler==PRESCALE-1. With PRESCALE=1, tick is high every RUN cycle.
  - Prescaler increments in RUN when not paused and wraps to 0 on tick.
- RUN, tick, count != limit_q: count<=count+1.
- RUN, tick, count == limit_q (terminal):
  - done<=1 for exactly one cycle; periods<=periods+1.
  - periodic_q=1: count<=0, stay in RUN.
  - periodic_q=0: count holds limit_q, go to IDLE.
- Timing: the counter dwells one tick on each value 0..limit_q. Period = (limit_q+1)*PRESCALE clocks from the RUN entry edge to the done edge. limit_q=0 gives done every PRESCALE clocks.
- pause=1 in RUN: go to HOLD; count and prescaler frozen; no tick. pause=0 in HOLD: return to RUN and resume the prescaler from its frozen value.
- abort=1 in any state: next state IDLE; count<=0; prescaler<=0; done<=0; periods hold. Abort on the terminal tick edge suppresses done.
- Boundaries:
  - start in RUN/HOLD is ignored.
  - limit/periodic changes after start have no effect until the next start.
  - start and abort together in IDLE: abort wins, stay in IDLE, count<=0.
  - pause and terminal condition in the same cycle: pause wins, no done.
  - count never exceeds limit_q.
  - Reset asserted mid-run forces all reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, HOLD=2'd2) and default WIDTH/PW.
- One natural sub-module, upcounter_core: WIDTH-bit counter with clear, enable and async reset, driven by the controller's clear/tick.
- FSM and prescaler live in upcounter_ctrl.

Test Plan:
- Reset then idle: reset=1 for 20 ns, then release -> count=0, busy=0, done=0, periods=0; holds for 10 cycles.
- One-shot: PRESCALE=1, limit=5, periodic=0, start for 1 cycle -> count 0,1,...,5 over 6 cycles; done high 1 cycle on the next edge; busy falls same edge; count stays 5; periods=1.
- Periodic with prescale: PRESCALE=2, limit=3, periodic=1 -> done every 8 clocks; count sequence 0,0,1,1,2,2,3,3,0; periods=3 after 24 clocks.
- Pause: limit=9 one-shot; pause high 4 cycles while count=4 -> state HOLD, count frozen at 4; run resumes; done arrives exactly 4 cycles later than the unpaused run.
- Abort: periodic limit=7; abort when count=6 -> next edge IDLE, count=0, no done, periods unchanged. A start during RUN is ignored (count unchanged).
- Async reset mid-run: reset asserted between edges while count=3 -> count=0, busy=0 before the next clock edge.

Source files
------------

// File: rtl/upcounter_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// upcounter_ctrl_pkg
// Shared definitions for the up-counter sequencing controller:
//   - state_e     : controller state encoding (IDLE/RUN/HOLD)
//   - DEF_WIDTH   : default counter/limit width
//   - DEF_PW      : default completed-period tally width
//   - presc_w()   : prescaler register width for a given PRESCALE value
// ---------------------------------------------------------------------------
package upcounter_ctrl_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_PW    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    // A prescaler of 1 still needs a one-bit register so the compare logic
    // stays uniform; it simply never leaves zero.
    function automatic int presc_w(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/upcounter_ctrl_if.sv
// ---------------------------------------------------------------------------
// upcounter_ctrl_if
// Control/status bundle between the sequencing logic (master) and the
// up-counter controller (slave).
//   start    : begin a run (honoured only when idle)
//   pause    : level, freezes counter and prescaler while high
//   abort    : terminate run immediately
//   periodic : sampled with start, 1 = auto-reload, 0 = one-shot
//   limit    : terminal count, sampled with start
//   count    : current counter value
//   busy     : controller is running or paused
//   done     : one-clock pulse per completed period
//   periods  : completed periods since last start (wraps)
// ---------------------------------------------------------------------------
interface upcounter_ctrl_if
    import upcounter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PW    = DEF_PW
) ();

    logic             start;
    logic             pause;
    logic             abort;
    logic             periodic;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic [PW-1:0]    periods;

    modport master (
        output start, pause, abort, periodic, limit,
        input  count, busy, done, periods
    );

    modport slave (
        input  start, pause, abort, periodic, limit,
        output count, busy, done, periods
    );

endinterface

// File: rtl/upcounter_core.sv
// ---------------------------------------------------------------------------
// upcounter_core
// Plain WIDTH-bit up-counter datapath.
//   clk_i   : rising-edge clock
//   rst_i   : asynchronous active-high reset (count -> 0)
//   clear_i : synchronous clear, has priority over en_i
//   en_i    : increment by one
//   count_o : current count
// ---------------------------------------------------------------------------
module upcounter_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/upcounter_ctrl.sv
// ---------------------------------------------------------------------------
// upcounter_ctrl
// Sequencing controller for a WIDTH-bit up-counter: latches a terminal
// limit, advances the counter once every PRESCALE clocks, supports one-shot
// or periodic operation, pause and abort, and reports busy, a one-cycle done
// pulse and a completed-period tally.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : upcounter_ctrl_if.slave (start/pause/abort/periodic/limit in,
//           count/busy/done/periods out)
// Edge priority: abort > pause > start > tick.
// ---------------------------------------------------------------------------
module upcounter_ctrl
    import upcounter_ctrl_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PRESCALE = 1,
    parameter int PW       = DEF_PW
) (
    input  logic             clock,
    input  logic             reset,
    upcounter_ctrl_if.slave  bus
);

    localparam int               PSW        = presc_w(PRESCALE);
    localparam logic [PSW-1:0]   PRESC_LAST = PSW'(PRESCALE - 1);

    state_e           state_q, state_d;
    logic [PSW-1:0]   presc_q, presc_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             periodic_q, periodic_d;
    logic             done_q, done_d;
    logic             busy_q;
    logic [PW-1:0]    periods_q, periods_d;

    logic             cnt_clear;
    logic             cnt_inc;
    logic [WIDTH-1:0] count;

    upcounter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk_i   (clock),
        .rst_i   (reset),
        .clear_i (cnt_clear),
        .en_i    (cnt_inc),
        .count_o (count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            limit_q    <= '0;
            periodic_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            periods_q  <= '0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            limit_q    <= limit_d;
            periodic_q <= periodic_d;
            done_q     <= done_d;
            busy_q     <= (state_d != IDLE);
            periods_q  <= periods_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        limit_d    = limit_q;
        periodic_d = periodic_q;
        done_d     = 1'b0;
        periods_d  = periods_q;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;

        if (bus.abort) begin
            state_d   = IDLE;
            presc_d   = '0;
            cnt_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        limit_d    = bus.limit;
                        periodic_d = bus.periodic;
                        presc_d    = '0;
                        periods_d  = '0;
                        cnt_clear  = 1'b1;
                        state_d    = RUN;
                    end
                end
                RUN, HOLD: begin
                    if (bus.pause) begin
                        state_d = HOLD;
                    end else begin
                        // The edge that releases a pause already advances the
                        // prescaler, so a pause costs exactly as many clocks
                        // as it was held high.
                        state_d = RUN;
                        if (presc_q == PRESC_LAST) begin
                            presc_d = '0;
                            if (count == limit_q) begin
                                done_d    = 1'b1;
                                periods_d = periods_q + PW'(1);
                                if (periodic_q) begin
                                    cnt_clear = 1'b1;
                                end else begin
                                    state_d = IDLE;
                                end
                            end else begin
                                cnt_inc = 1'b1;
                            end
                        end else begin
                            presc_d = presc_q + PSW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.count   = count;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.periods = periods_q;

endmodule

// File: tb/tb_upcounter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_upcounter_ctrl
// Two controllers (PRESCALE=1 and PRESCALE=2) share one stimulus stream and
// are each compared every cycle against an elapsed-time reference model.
// ---------------------------------------------------------------------------
module tb_upcounter_ctrl;

    localparam int W  = 4;
    localparam int PW = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         start, pause, abort, periodic;
    logic [W-1:0] limit;

    int checks = 0;
    int errors = 0;

    upcounter_ctrl_if #(.WIDTH(W), .PW(PW)) bus1 ();
    upcounter_ctrl_if #(.WIDTH(W), .PW(PW)) bus2 ();

    assign bus1.start = start;  assign bus2.start = start;
    assign bus1.pause = pause;  assign bus2.pause = pause;
    assign bus1.abort = abort;  assign bus2.abort = abort;
    assign bus1.periodic = periodic;  assign bus2.periodic = periodic;
    assign bus1.limit = limit;  assign bus2.limit = limit;

    upcounter_ctrl #(.WIDTH(W), .PRESCALE(1), .PW(PW)) dut1 (
        .clock (clock), .reset (reset), .bus (bus1.slave));
    upcounter_ctrl #(.WIDTH(W), .PRESCALE(2), .PW(PW)) dut2 (
        .clock (clock), .reset (reset), .bus (bus2.slave));

    always #5 clock = ~clock;

    // Reference model: progress is measured in unpaused running clocks since
    // the start of the current period; the counter value is that elapsed time
    // divided by the prescale, and a period ends after (limit+1)*prescale.
    int P [2] = '{1, 2};
    bit m_run [2];
    int m_el  [2];
    int m_cnt [2];
    int m_lim [2];
    bit m_per [2];
    int m_prd [2];
    bit m_done[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_el[i] = 0; m_cnt[i] = 0; m_lim[i] = 0;
            m_per[i] = 0; m_prd[i] = 0; m_done[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        m_done[i] = 0;
        if (abort) begin
            m_run[i] = 0; m_el[i] = 0; m_cnt[i] = 0;
        end else if (!m_run[i]) begin
            if (start) begin
                m_run[i] = 1; m_lim[i] = int'(limit); m_per[i] = periodic;
                m_el[i] = 0; m_cnt[i] = 0; m_prd[i] = 0;
            end
        end else if (!pause) begin
            m_el[i]++;
            if (m_el[i] == (m_lim[i] + 1) * P[i]) begin
                m_done[i] = 1;
                m_prd[i]  = (m_prd[i] + 1) % (1 << PW);
                m_el[i]   = 0;
                if (m_per[i]) m_cnt[i] = 0;
                else begin m_cnt[i] = m_lim[i]; m_run[i] = 0; end
            end else begin
                m_cnt[i] = m_el[i] / P[i];
            end
        end
    endtask

    task automatic check_all();
        check("d1.count",   bus1.count,   m_cnt[0]);
        check("d1.busy",    bus1.busy,    m_run[0]);
        check("d1.done",    bus1.done,    m_done[0]);
        check("d1.periods", bus1.periods, m_prd[0]);
        check("d2.count",   bus2.count,   m_cnt[1]);
        check("d2.busy",    bus2.busy,    m_run[1]);
        check("d2.done",    bus2.done,    m_done[1]);
        check("d2.periods", bus2.periods, m_prd[1]);
    endtask

    // One clock: the model follows the active edge, outputs are checked on
    // the falling edge, and the caller then drives the next inputs.
    task automatic cycle();
        @(posedge clock);
        #1;
        model_step(0);
        model_step(1);
        @(negedge clock);
        check_all();
    endtask

    task automatic idle_inputs();
        start = 0; pause = 0; abort = 0;
    endtask

    task automatic start_run(input int lim, input bit per);
        limit = W'(lim); periodic = per; start = 1;
        cycle();
        start = 0;
    endtask

    int  n, done_at, prd_before;
    bit  found, paused;

    initial begin
        reset = 1; idle_inputs(); periodic = 0; limit = '0;
        model_reset();
        #20;
        @(negedge clock);
        reset = 0;
        check("rst.count", bus1.count, 0);
        check("rst.busy", bus1.busy, 0);
        check("rst.periods", bus2.periods, 0);
        for (int k = 0; k < 10; k++) cycle();

        // One-shot, limit 5: done six clocks after the start edge.
        start_run(5, 0);
        found = 0; done_at = 0;
        for (n = 1; n <= 20 && !found; n++) begin
            cycle();
            if (bus1.done) begin found = 1; done_at = n; end
        end
        check("oneshot.seen", found, 1);
        check("oneshot.latency", done_at, 6);
        check("oneshot.busy", bus1.busy, 0);
        check("oneshot.count", bus1.count, 5);
        check("oneshot.periods", bus1.periods, 1);
        for (int k = 0; k < 20; k++) cycle();

        // Periodic, limit 3: the prescale-2 unit completes a period every 8.
        start_run(3, 1);
        for (int k = 0; k < 24; k++) cycle();
        check("periodic.d2.periods", bus2.periods, 3);
        check("periodic.d1.periods", bus1.periods, 6);
        abort = 1; cycle(); abort = 0;

        // Pause for 4 clocks at count 4 delays done by exactly 4 clocks.
        start_run(9, 0);
        found = 0; paused = 0; done_at = 0;
        for (n = 1; n <= 60 && !found; n++) begin
            if (!paused && bus1.count == 4) begin
                paused = 1;
                pause = 1;
                for (int k = 0; k < 4; k++) begin
                    cycle();
                    if (k == 0) check("pause.count", bus1.count, 4);
                    n++;
                end
                pause = 0;
            end
            cycle();
            if (bus1.done) begin found = 1; done_at = n; end
        end
        check("pause.seen", found, 1);
        check("pause.latency", done_at, 14);
        for (int k = 0; k < 30; k++) cycle();

        // Start during a run is ignored; abort at count 6 clears without done.
        start_run(7, 1);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (bus1.count == 2) begin
                limit = W'(1); start = 1; cycle(); start = 0;
                check("restart.ignored", bus1.count, 3);
            end
            if (bus1.count == 6) found = 1;
            else cycle();
        end
        check("abort.reach6", found, 1);
        prd_before = int'(bus1.periods);
        abort = 1; cycle(); abort = 0;
        check("abort.count", bus1.count, 0);
        check("abort.busy", bus1.busy, 0);
        check("abort.done", bus1.done, 0);
        check("abort.periods", bus1.periods, prd_before);

        // Asynchronous reset between edges while count is 3.
        start_run(9, 1);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (bus1.count == 3) found = 1;
            else cycle();
        end
        check("areset.reach3", found, 1);
        #2 reset = 1;
        #1;
        check("areset.count", bus1.count, 0);
        check("areset.busy", bus1.busy, 0);
        check("areset.d2busy", bus2.busy, 0);
        model_reset();
        @(negedge clock);
        reset = 0;
        check_all();

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            start    = ($urandom_range(0, 7) == 0);
            pause    = ($urandom_range(0, 5) == 0);
            abort    = ($urandom_range(0, 39) == 0);
            periodic = $urandom_range(0, 1);
            limit    = W'($urandom_range(0, (1 << W) - 1));
            cycle();
        end
        idle_inputs();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
